// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM states, access-size codes
// and the grant priority rule.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  localparam logic [2:0] dm_word              = 3'd0;
  localparam logic [2:0] dm_halfword          = 3'd1;
  localparam logic [2:0] dm_halfword_unsigned = 3'd2;
  localparam logic [2:0] dm_byte              = 3'd3;
  localparam logic [2:0] dm_byte_unsigned     = 3'd4;

  localparam int WDT_W = 8;

  // Data normally wins; fetch takes its turn when data won last time.
  function automatic logic pick_data(input logic d_req, input logic if_req,
                                     input logic last_data);
    return d_req & ~(if_req & last_data);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_bus_wdt.sv
// Bus watchdog: counts stalled bus cycles and flags expiry at the limit.
// A limit of zero disables expiry; the count saturates instead of wrapping.
module bus_wdt
  import mem_port_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WDT_W-1:0] limit,
  output logic             expired
);

  logic [WDT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (limit != '0) && (count == limit);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus port between the fetch and data requesters, one
// access at a time, with a watchdog abort for transactions that never finish.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_dmtype,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [2:0]  bus_dmtype,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic        bus_err
);

  arb_state_t  state;
  arb_state_t  next_state;
  logic        grant_data;
  logic        err_flag;
  logic [31:0] rdata;
  logic        expired;
  logic        any_req;
  logic        win_data;

  assign any_req  = if_req | d_req;
  assign win_data = pick_data(d_req, if_req, grant_data);

  bus_wdt u_wdt (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == ARB_IDLE),
    .enable  ((state == ARB_BUSY) && !bus_ready),
    .limit   (WDT_W'(BUS_TIMEOUT)),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // RESP always returns to IDLE so a requester's stale req is not re-served.
  always_comb begin
    next_state = state;
    case (state)
      ARB_IDLE: if (any_req) next_state = ARB_BUSY;
      ARB_BUSY: if (bus_ready || expired) next_state = ARB_RESP;
      ARB_RESP: next_state = ARB_IDLE;
      default:  next_state = ARB_IDLE;
    endcase
  end

  always_comb begin
    bus_req  = 1'b0;
    if_valid = 1'b0;
    d_valid  = 1'b0;
    bus_err  = 1'b0;
    case (state)
      ARB_BUSY: bus_req = 1'b1;
      ARB_RESP: begin
        d_valid  = grant_data;
        if_valid = ~grant_data;
        bus_err  = err_flag;
      end
      default: ;
    endcase
  end

  // grant_data doubles as the last-grant memory used by the priority rule.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_data <= 1'b0;
      err_flag   <= 1'b0;
      rdata      <= '0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_dmtype <= dm_word;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            grant_data <= win_data;
            err_flag   <= 1'b0;
            if (win_data) begin
              bus_we     <= d_we;
              bus_addr   <= d_addr;
              bus_wdata  <= d_wdata;
              bus_dmtype <= d_dmtype;
            end else begin
              bus_we     <= 1'b0;
              bus_addr   <= if_addr;
              bus_wdata  <= '0;
              bus_dmtype <= dm_word;
            end
          end
        end
        ARB_BUSY: begin
          if (bus_ready) begin
            rdata <= bus_rdata;
          end else if (expired) begin
            rdata    <= '0;
            err_flag <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign if_rdata = rdata;
  assign d_rdata  = rdata;
  assign stall    = (if_req & ~if_valid) | (d_req & ~d_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: requester queues and a bus responder driven from a
// transaction-level timing model (grant cycle, wait count, completion cycle).
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int TIMEOUT = 4;
  localparam int NEVER   = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [2:0]  d_dmtype = '0;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [2:0]  bus_dmtype;
  logic [31:0] bus_rdata = '0;
  logic        bus_ready = 1'b0;
  logic        bus_err;

  mem_port_arbiter #(.BUS_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_dmtype(d_dmtype), .d_rdata(d_rdata), .d_valid(d_valid),
    .stall(stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_dmtype(bus_dmtype), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  dm;
  } op_t;

  op_t if_q[$];
  op_t d_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model of the access in flight
  op_t         cur_op;
  bit          active = 0, who_d = 0, never = 0, last_data = 0;
  int          g = 0, d = 0, w = 0, v = 0, cyc = 0;
  logic [31:0] saved = '0;
  bit          in_busy, exp_v, exp_ifv, exp_dv, exp_err;

  int          wait_mode = -1;
  bit          use_force = 0;
  logic [31:0] rdata_force = '0;
  bit          rand_en = 0, keep_full = 0, cont_phase = 0;
  bit          if_new = 1, d_new = 1, have_prev = 0, prev_d = 0;
  int          if_start = 0, d_start = 0, max_wait = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic op_t rand_op(input bit is_data);
    op_t o;
    o.we    = is_data ? 1'($urandom_range(0, 1)) : 1'b0;
    o.addr  = $urandom;
    o.wdata = is_data ? $urandom : 32'h0;
    o.dm    = is_data ? 3'($urandom_range(0, 4)) : dm_word;
    return o;
  endfunction

  // One clock cycle: entered and left at posedge+1.
  task automatic applyStimulus();
    int r;
    if (keep_full || (rand_en && $urandom_range(0, 2) == 0))
      if (if_q.size() == 0) if_q.push_back(rand_op(0));
    if (keep_full || (rand_en && $urandom_range(0, 2) == 0))
      if (d_q.size() == 0) d_q.push_back(rand_op(1));
    if (if_q.size() != 0 && if_new) begin if_start = cyc; if_new = 0; end
    if (d_q.size() != 0 && d_new) begin d_start = cyc; d_new = 0; end

    if_req = (if_q.size() != 0);
    if (if_req) if_addr = if_q[0].addr;
    d_req = (d_q.size() != 0);
    if (d_req) begin
      d_we = d_q[0].we; d_addr = d_q[0].addr; d_wdata = d_q[0].wdata; d_dmtype = d_q[0].dm;
    end

    if (!active && (if_req || d_req)) begin
      who_d = d_req && !(if_req && last_data);
      last_data = who_d;
      if (who_d) cur_op = d_q[0];
      else begin
        cur_op.we = 1'b0; cur_op.addr = if_q[0].addr; cur_op.wdata = '0; cur_op.dm = dm_word;
      end
      if (wait_mode < 0) begin
        r = $urandom_range(0, 9);
        never = (r == 9);
        w = r % 4;
      end else begin
        never = (wait_mode == NEVER);
        w = never ? 0 : wait_mode;
      end
      d = never ? TIMEOUT : w;
      g = cyc;
      v = g + 2 + d;
      active = 1;
    end

    in_busy = active && (cyc >= g + 1) && (cyc <= g + 1 + d);
    if (in_busy) bus_ready = !never && (cyc == g + 1 + w);
    else bus_ready = 1'($urandom_range(0, 1));
    bus_rdata = use_force ? rdata_force : $urandom;
    if (in_busy && bus_ready) saved = bus_rdata;
    exp_v   = active && (cyc == v);
    exp_ifv = exp_v && !who_d;
    exp_dv  = exp_v && who_d;
    exp_err = exp_v && never;

    @(negedge clk);
    checkOutput("bus_req", bus_req, in_busy);
    checkOutput("if_valid", if_valid, exp_ifv);
    checkOutput("d_valid", d_valid, exp_dv);
    checkOutput("bus_err", bus_err, exp_err);
    checkOutput("stall", stall, (if_req && !exp_ifv) || (d_req && !exp_dv));
    if (in_busy) begin
      checkOutput("bus_addr", bus_addr, cur_op.addr);
      checkOutput("bus_we", bus_we, cur_op.we);
      checkOutput("bus_wdata", bus_wdata, cur_op.wdata);
      checkOutput("bus_dmtype", bus_dmtype, cur_op.dm);
    end
    if (exp_ifv) checkOutput("if_rdata", if_rdata, never ? 32'h0 : saved);
    if (exp_dv && (!cur_op.we || never)) checkOutput("d_rdata", d_rdata, never ? 32'h0 : saved);
    if (cont_phase) begin
      if (if_valid && (cyc - if_start > max_wait)) max_wait = cyc - if_start;
      if (d_valid && (cyc - d_start > max_wait)) max_wait = cyc - d_start;
      if (if_valid || d_valid) begin
        if (have_prev) checkOutput("alternate", d_valid, !prev_d);
        prev_d = d_valid;
        have_prev = 1;
      end
    end

    @(posedge clk); #1;
    if (exp_v) begin
      active = 0;
      if (who_d) begin void'(d_q.pop_front()); d_new = 1; end
      else begin void'(if_q.pop_front()); if_new = 1; end
    end
    cyc++;
  endtask

  task automatic drain();
    int guard = 0;
    while ((if_q.size() != 0 || d_q.size() != 0 || active) && guard < 300) begin
      applyStimulus();
      guard++;
    end
    if (guard >= 300) checkOutput("drain_timeout", 0, 1);
  endtask

  task automatic check_reset_values(input string pfx);
    checkOutput({pfx, "_bus_req"}, bus_req, 0);
    checkOutput({pfx, "_bus_we"}, bus_we, 0);
    checkOutput({pfx, "_if_valid"}, if_valid, 0);
    checkOutput({pfx, "_d_valid"}, d_valid, 0);
    checkOutput({pfx, "_bus_err"}, bus_err, 0);
    checkOutput({pfx, "_bus_addr"}, bus_addr, 0);
    checkOutput({pfx, "_bus_wdata"}, bus_wdata, 0);
    checkOutput({pfx, "_if_rdata"}, if_rdata, 0);
    checkOutput({pfx, "_d_rdata"}, d_rdata, 0);
    checkOutput({pfx, "_bus_dmtype"}, bus_dmtype, 0);
  endtask

  initial begin
    op_t o;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("rst");
    rst = 1'b1;
    @(posedge clk); #1;

    // Fetch only, zero wait
    wait_mode = 0; use_force = 1; rdata_force = 32'h0000_0093;
    o.we = 0; o.addr = 32'h0000_0010; o.wdata = 0; o.dm = dm_word;
    if_q.push_back(o);
    drain();
    use_force = 0;

    // Simultaneous fetch and data load
    o.addr = 32'h0000_0014; if_q.push_back(o);
    o.we = 0; o.addr = 32'h0000_0100; o.wdata = 0; o.dm = dm_word; d_q.push_back(o);
    drain();

    // Byte store with three wait states
    wait_mode = 3;
    o.we = 1; o.addr = 32'h0000_0200; o.wdata = 32'hDEAD_BEEF; o.dm = dm_byte;
    d_q.push_back(o);
    drain();

    // Bus never answers: watchdog abort
    wait_mode = NEVER;
    o.we = 0; o.addr = 32'h0000_0300; o.wdata = 0; o.dm = dm_word;
    d_q.push_back(o);
    drain();

    // Reset asserted while the bus is busy
    wait_mode = 3;
    o.addr = 32'h0000_0400; d_q.push_back(o);
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    #1;
    check_reset_values("midrst");
    if_q.delete(); d_q.delete();
    active = 0; last_data = 0; if_new = 1; d_new = 1;
    if_req = 0; d_req = 0; bus_ready = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    cyc++;
    repeat (3) applyStimulus();
    wait_mode = 1;
    o.addr = 32'h0000_0500; d_q.push_back(o);
    drain();

    // Continuous contention: grants must alternate
    wait_mode = 0; keep_full = 1; cont_phase = 1; have_prev = 0; max_wait = 0;
    repeat (24) applyStimulus();
    keep_full = 0;
    cont_phase = 0;
    drain();
    checkOutput("max_wait_le_6", (max_wait <= 6 && max_wait > 0), 1);

    // Randomized traffic with random waits and occasional aborts
    wait_mode = -1; rand_en = 1;
    repeat (600) applyStimulus();
    rand_en = 0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
